alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage.sv | 144 ++++++++++++++
 tb/tb_alu_decode_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: single-entry decode register between ID and EX.
// Decodes a MIPS instruction word into ALU controls, an extended immediate
// and a shift amount, with valid/ready handshaking and a flush input.
// Optional feature macro: ALU_DECODE_ILLEGAL_CNT_EN enables a saturating
// count of accepted instructions that decode to the undefined ALU op.
module alu_decode_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  aluOP,
  output logic [4:0]  shamt,
  output logic        alu_src_imm,
  output logic [31:0] imm32,
  output logic        illegal,
  output logic [15:0] illegal_cnt
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRA   = 4'd6;
  localparam logic [3:0] ALU_UNDEF = 4'd7;

  logic [5:0]  opcode, funct;
  logic [3:0]  dec_op;
  logic        dec_src_imm;
  logic [31:0] dec_imm;
  logic        accept;

  logic        valid_q, valid_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  shamt_q, shamt_d;
  logic        src_q, src_d;
  logic [31:0] imm_q, imm_d;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign in_ready = !valid_q || out_ready;
  // A flush squashes the incoming instruction even when the handshake fires.
  assign accept   = in_valid && in_ready && !flush;

  // Combinational instruction decode of the presented word.
  always_comb begin
    dec_op      = ALU_UNDEF;
    dec_src_imm = 1'b0;
    dec_imm     = {{16{instr[15]}}, instr[15:0]};
    if (opcode == 6'h00) begin
      unique case (funct)
        6'h20, 6'h21: dec_op = ALU_ADD;
        6'h22, 6'h23: dec_op = ALU_SUB;
        6'h24:        dec_op = ALU_AND;
        6'h25:        dec_op = ALU_OR;
        6'h2A:        dec_op = ALU_SLT;
        6'h00:        dec_op = ALU_SLL;
        6'h03:        dec_op = ALU_SRA;
        default:      dec_op = ALU_UNDEF;
      endcase
    end else begin
      unique case (opcode)
        6'h08, 6'h09, 6'h23, 6'h2B: begin dec_op = ALU_ADD; dec_src_imm = 1'b1; end
        6'h0C: begin dec_op = ALU_AND; dec_src_imm = 1'b1; end
        6'h0D: begin dec_op = ALU_OR;  dec_src_imm = 1'b1; end
        6'h0A: begin dec_op = ALU_SLT; dec_src_imm = 1'b1; end
        6'h04: dec_op = ALU_SUB;  // beq compares two registers
        default: dec_op = ALU_UNDEF;
      endcase
      // Logical immediates are zero-extended.
      if (opcode == 6'h0C || opcode == 6'h0D) dec_imm = {16'h0000, instr[15:0]};
    end
  end

  // Next-state for the payload register: load on accept, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    src_d   = src_q;
    imm_d   = imm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      shamt_d = instr[10:6];
      src_d   = dec_src_imm;
      imm_d   = dec_imm;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Payload register with synchronous reset to the empty/undef state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      op_q    <= ALU_UNDEF;
      shamt_q <= 5'd0;
      src_q   <= 1'b0;
      imm_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
    end
  end

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of accepted (non-flushed) undefined instructions.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_op == ALU_UNDEF && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = 16'h0000;
`endif

  assign out_valid   = valid_q;
  assign aluOP       = op_q;
  assign shamt       = shamt_q;
  assign alu_src_imm = src_q;
  assign imm32       = imm_q;
  assign illegal     = valid_q && (op_q == ALU_UNDEF);

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized bench for alu_decode_stage against a table-driven reference model.
module tb_alu_decode_stage;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, imm32;
  logic [3:0]  aluOP;
  logic [4:0]  shamt;
  logic        alu_src_imm, illegal;
  logic [15:0] illegal_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: what the EX side should see.
  logic        m_valid;
  logic [3:0]  m_op;
  logic [4:0]  m_shamt;
  logic        m_src;
  logic [31:0] m_imm;
  int          m_cnt;

  // Decode tables taken straight from the instruction lists.
  logic [5:0] r_funct [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h03};
  logic [3:0] r_op    [9] = '{4'd0,  4'd0,  4'd1,  4'd1,  4'd3,  4'd2,  4'd4,  4'd5,  4'd6};
  logic [5:0] i_opc   [8] = '{6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A, 6'h04};
  logic [3:0] i_op    [8] = '{4'd0,  4'd0,  4'd0,  4'd0,  4'd3,  4'd2,  4'd4,  4'd1};

  alu_decode_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .aluOP(aluOP), .shamt(shamt), .alu_src_imm(alu_src_imm), .imm32(imm32),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [31:0] w, output logic [3:0] op,
                            output logic src, output logic [31:0] imm);
    logic [15:0] lo;
    lo  = w[15:0];
    op  = 4'd7;
    src = 1'b0;
    imm = {{16{lo[15]}}, lo};
    if (w[31:26] == 6'h00) begin
      for (int k = 0; k < 9; k++) if (w[5:0] == r_funct[k]) op = r_op[k];
    end else begin
      for (int k = 0; k < 8; k++)
        if (w[31:26] == i_opc[k]) begin
          op  = i_op[k];
          src = (w[31:26] != 6'h04);
        end
      if (w[31:26] == 6'h0C || w[31:26] == 6'h0D) imm = {16'h0000, lo};
    end
  endtask

  task automatic check_outs(input string tag);
    int ec;
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    ec = m_cnt;
`else
    ec = 0;
`endif
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".aluOP"}, aluOP, m_op);
    chk({tag, ".shamt"}, shamt, m_shamt);
    chk({tag, ".src_imm"}, alu_src_imm, m_src);
    chk({tag, ".imm32"}, imm32, m_imm);
    chk({tag, ".illegal"}, illegal, m_valid && m_op == 4'd7);
    chk({tag, ".illegal_cnt"}, illegal_cnt, ec[15:0]);
  endtask

  // One clock: drive at negedge, check ready, advance model on posedge, check outputs.
  task automatic cyc(input string tag, input logic rst_n, input logic iv,
                     input logic [31:0] w, input logic fl, input logic ordy);
    logic       rdy;
    logic [3:0] op;
    logic       src;
    logic [31:0] imm;
    reset_n = rst_n; in_valid = iv; instr = w; flush = fl; out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    if (rst_n) chk({tag, ".in_ready"}, in_ready, rdy);
    @(posedge clk);
    ref_decode(w, op, src, imm);
    if (!rst_n) begin
      m_valid = 0; m_op = 4'd7; m_shamt = 0; m_src = 0; m_imm = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0;
    end else if (iv && rdy) begin
      m_valid = 1; m_op = op; m_shamt = w[10:6]; m_src = src; m_imm = imm;
      if (op == 4'd7 && m_cnt < 65535) m_cnt++;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_outs(tag);
    if (!rst_n) chk({tag, ".rst_ready"}, in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: begin w[31:26] = 6'h00; w[5:0] = r_funct[$urandom_range(0, 8)]; end
      1: w[31:26] = i_opc[$urandom_range(0, 7)];
      2: w[31:26] = 6'h00;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    m_valid = 0; m_op = 4'd7; m_shamt = 0; m_src = 0; m_imm = 0; m_cnt = 0;
    reset_n = 0; in_valid = 0; instr = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    cyc("reset", 0, 1, 32'h012A4020, 1, 1);
    chk("reset.aluOP_undef", aluOP, 4'd7);
    // add
    cyc("add", 1, 1, 32'h012A4020, 0, 1);
    chk("add.op", aluOP, 4'd0);
    // ori / addi immediates
    cyc("ori", 1, 1, 32'h3508FFFF, 0, 1);
    chk("ori.imm", imm32, 32'h0000FFFF);
    cyc("addi", 1, 1, 32'h2108FFFF, 0, 1);
    chk("addi.imm", imm32, 32'hFFFFFFFF);
    // backpressure: 3 stalled cycles, then release with no bubble
    for (int i = 0; i < 3; i++) cyc("stall", 1, 1, 32'h01095022, 0, 0);
    chk("stall.op_held", aluOP, 4'd0);
    cyc("release", 1, 1, 32'h01095022, 0, 1);
    cyc("nobubble", 1, 1, 32'h0109502A, 0, 1);
    chk("nobubble.op", aluOP, 4'd4);
    // flush with full register and incoming instruction
    cyc("flush", 1, 1, 32'h3508FFFF, 1, 0);
    chk("flush.valid", out_valid, 1'b0);
    // illegal opcode
    cyc("illegal", 1, 1, 32'hFC000000, 0, 1);
    chk("illegal.flag", illegal, 1'b1);
    // flushed illegal must not count
    cyc("ill_flush", 1, 1, 32'hFC000000, 1, 1);
    // drain
    cyc("drain", 1, 0, 32'h0, 0, 1);
    // reset while full
    cyc("fill", 1, 1, 32'h00085140, 0, 0);
    cyc("rst_full", 0, 1, 32'h2108FFFF, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
          rand_instr(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
